// File: rtl/load_writeback_unit.sv
// Load/writeback sequencer: issues one word read per load, extracts and extends the lane, writes the register file.
// Optional halfword loads (LH/LHU) are enabled by defining LOAD_HALFWORD_EN.
module load_writeback_unit #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [4:0]  req_rd,
  output logic        mem_rd_valid,
  input  logic        mem_rd_ready,
  output logic [31:0] mem_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        rf_wr_enable,
  output logic [4:0]  rf_wr_address,
  output logic [31:0] rf_wr_data,
  output logic [2:0]  rf_write_pattern,
  output logic        busy,
  output logic        error
);

  // state | meaning
  // IDLE  | ready for a request; illegal requests pulse error here
  // ISSUE | mem_rd_valid held until the memory accepts the read
  // WAIT  | waiting for read data, bounded by MEM_TIMEOUT cycles
  // WRITE | one-cycle register-file write of the extracted data
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WRITE} state_t;

  localparam logic [2:0] REGISTER_WRITE_WORD = 3'b010;
  localparam logic [7:0] TIMEOUT_LAST        = 8'(MEM_TIMEOUT - 1);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [1:0]  addr_lo_q;
  logic [2:0]  funct3_q;
  logic [4:0]  rd_q;
  logic        req_legal;
  logic [7:0]  byte_sel;
  logic [31:0] load_data;
`ifdef LOAD_HALFWORD_EN
  logic [15:0] half_sel;
`endif

  assign rf_write_pattern = REGISTER_WRITE_WORD;

  always_comb begin
    req_legal = 1'b0;
    case (req_funct3)
      3'b000, 3'b100: req_legal = 1'b1;
      3'b010:         req_legal = (req_addr[1:0] == 2'b00);
`ifdef LOAD_HALFWORD_EN
      3'b001, 3'b101: req_legal = ~req_addr[0];
`endif
      default:        req_legal = 1'b0;
    endcase
  end

  always_comb begin
    case (addr_lo_q)
      2'd0:    byte_sel = mem_resp_data[7:0];
      2'd1:    byte_sel = mem_resp_data[15:8];
      2'd2:    byte_sel = mem_resp_data[23:16];
      default: byte_sel = mem_resp_data[31:24];
    endcase
  end

`ifdef LOAD_HALFWORD_EN
  assign half_sel = addr_lo_q[1] ? mem_resp_data[31:16] : mem_resp_data[15:0];
`endif

  always_comb begin
    load_data = mem_resp_data;
    case (funct3_q)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_data = {24'h000000, byte_sel};
`ifdef LOAD_HALFWORD_EN
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_data = {16'h0000, half_sel};
`endif
      default: load_data = mem_resp_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      wait_cnt      <= 8'd0;
      addr_lo_q     <= 2'b00;
      funct3_q      <= 3'b000;
      rd_q          <= 5'd0;
      req_ready     <= 1'b1;
      busy          <= 1'b0;
      mem_rd_valid  <= 1'b0;
      mem_addr      <= 32'h0;
      rf_wr_enable  <= 1'b0;
      rf_wr_address <= 5'd0;
      rf_wr_data    <= 32'h0;
      error         <= 1'b0;
    end else begin
      error <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            if (req_legal) begin
              state        <= ISSUE;
              addr_lo_q    <= req_addr[1:0];
              funct3_q     <= req_funct3;
              rd_q         <= req_rd;
              mem_addr     <= {req_addr[31:2], 2'b00};
              mem_rd_valid <= 1'b1;
              req_ready    <= 1'b0;
              busy         <= 1'b1;
            end else begin
              error <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (mem_rd_ready) begin
            state        <= WAIT;
            mem_rd_valid <= 1'b0;
            wait_cnt     <= 8'd0;
          end
        end
        WAIT: begin
          if (mem_resp_valid) begin
            state         <= WRITE;
            rf_wr_enable  <= (rd_q != 5'd0);
            rf_wr_address <= rd_q;
            rf_wr_data    <= load_data;
          end else if (wait_cnt == TIMEOUT_LAST) begin
            state     <= IDLE;
            error     <= 1'b1;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        WRITE: begin
          state        <= IDLE;
          rf_wr_enable <= 1'b0;
          req_ready    <= 1'b1;
          busy         <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_writeback_unit.sv
// Self-checking bench for load_writeback_unit: table of loads plus backpressure, timeout and reset sequences.
// Halfword expectations follow LOAD_HALFWORD_EN as the design does.
module tb_load_writeback_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [4:0]  req_rd;
  logic        mem_rd_valid;
  logic        mem_rd_ready;
  logic [31:0] mem_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        rf_wr_enable;
  logic [4:0]  rf_wr_address;
  logic [31:0] rf_wr_data;
  logic [2:0]  rf_write_pattern;
  logic        busy;
  logic        error;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] word;
    bit          is_err;
    logic [31:0] data;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  vec_t vec[$];
  wr_t  sb[$];

  load_writeback_unit #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_funct3(req_funct3), .req_rd(req_rd),
    .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready), .mem_addr(mem_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .rf_wr_enable(rf_wr_enable), .rf_wr_address(rf_wr_address), .rf_wr_data(rf_wr_data),
    .rf_write_pattern(rf_write_pattern), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every observed register write must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n && rf_wr_enable) begin
      if (sb.size() == 0) begin
        chk("unexpected_write_rd", {27'd0, rf_wr_address}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("sb_rd", {27'd0, rf_wr_address}, {27'd0, e.rd});
        chk("sb_data", rf_wr_data, e.data);
        chk("sb_pattern", {29'd0, rf_write_pattern}, 32'd2);
      end
    end
  end

  task automatic run_load(input vec_t v);
    wr_t w;
    req_addr       = v.addr;
    req_funct3     = v.f3;
    req_rd         = v.rd;
    mem_resp_data  = v.word;
    mem_rd_ready   = 1'b1;
    mem_resp_valid = 1'b1;
    req_valid      = 1'b1;
    chk("ready_before", {31'd0, req_ready}, 32'd1);
    if (!v.is_err && v.rd != 5'd0) begin
      w.rd = v.rd;
      w.data = v.data;
      sb.push_back(w);
    end
    tick();
    req_valid = 1'b0;
    if (v.is_err) begin
      chk("err_pulse", {31'd0, error}, 32'd1);
      chk("err_busy", {31'd0, busy}, 32'd0);
      chk("err_memvalid", {31'd0, mem_rd_valid}, 32'd0);
      chk("err_ready", {31'd0, req_ready}, 32'd1);
      tick();
      chk("err_clear", {31'd0, error}, 32'd0);
      chk("err_memvalid2", {31'd0, mem_rd_valid}, 32'd0);
    end else begin
      chk("issue_valid", {31'd0, mem_rd_valid}, 32'd1);
      chk("issue_addr", mem_addr, {v.addr[31:2], 2'b00});
      chk("issue_busy", {31'd0, busy}, 32'd1);
      chk("issue_ready", {31'd0, req_ready}, 32'd0);
      tick();
      chk("wait_valid", {31'd0, mem_rd_valid}, 32'd0);
      chk("wait_we", {31'd0, rf_wr_enable}, 32'd0);
      tick();
      chk("write_we", {31'd0, rf_wr_enable}, {31'd0, v.rd != 5'd0});
      chk("write_rd", {27'd0, rf_wr_address}, {27'd0, v.rd});
      chk("write_data", rf_wr_data, v.data);
      chk("write_err", {31'd0, error}, 32'd0);
      tick();
      chk("done_we", {31'd0, rf_wr_enable}, 32'd0);
      chk("done_busy", {31'd0, busy}, 32'd0);
      chk("done_ready", {31'd0, req_ready}, 32'd1);
      chk("done_hold", rf_wr_data, v.data);
    end
    mem_resp_valid = 1'b0;
  endtask

  initial begin
    wr_t w;
    vec.push_back('{32'h0000_0103, 3'b100, 5'd5,  32'h80AA_BBCC, 1'b0, 32'h0000_0080});
    vec.push_back('{32'h0000_0103, 3'b000, 5'd6,  32'h80AA_BBCC, 1'b0, 32'hFFFF_FF80});
    vec.push_back('{32'h0000_0100, 3'b010, 5'd7,  32'h80AA_BBCC, 1'b0, 32'h80AA_BBCC});
    vec.push_back('{32'h0000_0102, 3'b010, 5'd8,  32'h80AA_BBCC, 1'b1, 32'h0});
    vec.push_back('{32'h0000_0100, 3'b000, 5'd9,  32'h80AA_BBCC, 1'b0, 32'hFFFF_FFCC});
    vec.push_back('{32'h0000_0101, 3'b100, 5'd10, 32'h80AA_BBCC, 1'b0, 32'h0000_00BB});
    vec.push_back('{32'h0000_0102, 3'b000, 5'd11, 32'h1234_5678, 1'b0, 32'h0000_0034});
    vec.push_back('{32'h0000_0000, 3'b011, 5'd12, 32'h1234_5678, 1'b1, 32'h0});
    vec.push_back('{32'h0000_0000, 3'b110, 5'd12, 32'h1234_5678, 1'b1, 32'h0});
    vec.push_back('{32'h0000_0000, 3'b111, 5'd12, 32'h1234_5678, 1'b1, 32'h0});
`ifdef LOAD_HALFWORD_EN
    vec.push_back('{32'h0000_0102, 3'b001, 5'd13, 32'h80AA_BBCC, 1'b0, 32'hFFFF_80AA});
    vec.push_back('{32'h0000_0100, 3'b101, 5'd14, 32'h80AA_BBCC, 1'b0, 32'h0000_BBCC});
`else
    vec.push_back('{32'h0000_0102, 3'b001, 5'd13, 32'h80AA_BBCC, 1'b1, 32'h0});
    vec.push_back('{32'h0000_0100, 3'b101, 5'd14, 32'h80AA_BBCC, 1'b1, 32'h0});
`endif
    vec.push_back('{32'h0000_0101, 3'b001, 5'd15, 32'h80AA_BBCC, 1'b1, 32'h0});
    vec.push_back('{32'h0000_0200, 3'b010, 5'd0,  32'h5555_AAAA, 1'b0, 32'h5555_AAAA});
    vec.push_back('{32'h0000_0201, 3'b010, 5'd16, 32'h5555_AAAA, 1'b1, 32'h0});
    vec.push_back('{32'hFFFF_FFFC, 3'b010, 5'd31, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF});

    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_funct3 = '0; req_rd = '0;
    mem_rd_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    tick();
    tick();
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_memvalid", {31'd0, mem_rd_valid}, 32'd0);
    chk("rst_we", {31'd0, rf_wr_enable}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_rd", {27'd0, rf_wr_address}, 32'd0);
    chk("rst_data", rf_wr_data, 32'd0);
    chk("rst_pattern", {29'd0, rf_write_pattern}, 32'd2);
    chk("rst_memaddr", mem_addr, 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < vec.size(); i++) run_load(vec[i]);

    // Backpressure on issue, then a late response.
    req_addr = 32'h0000_0302; req_funct3 = 3'b100; req_rd = 5'd20;
    mem_resp_data = 32'hA1B2_C3D4; mem_rd_ready = 1'b0; mem_resp_valid = 1'b0;
    w.rd = 5'd20; w.data = 32'h0000_00B2; sb.push_back(w);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_valid_held", {31'd0, mem_rd_valid}, 32'd1);
      chk("bp_addr_held", mem_addr, 32'h0000_0300);
    end
    mem_rd_ready = 1'b1;
    tick();
    mem_rd_ready = 1'b0;
    chk("bp_handshake", {31'd0, mem_rd_valid}, 32'd0);
    for (int i = 0; i < 5; i++) tick();
    chk("bp_still_busy", {31'd0, busy}, 32'd1);
    chk("bp_no_we", {31'd0, rf_wr_enable}, 32'd0);
    mem_resp_valid = 1'b1;
    tick();
    mem_resp_valid = 1'b0;
    chk("bp_we", {31'd0, rf_wr_enable}, 32'd1);
    chk("bp_data", rf_wr_data, 32'h0000_00B2);
    tick();

    // Timeout: no response for 16 WAIT cycles.
    req_addr = 32'h0000_0400; req_funct3 = 3'b010; req_rd = 5'd21; mem_rd_ready = 1'b1;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    for (int i = 0; i < 15; i++) tick();
    chk("to_not_yet_err", {31'd0, error}, 32'd0);
    chk("to_not_yet_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("to_err", {31'd0, error}, 32'd1);
    chk("to_busy", {31'd0, busy}, 32'd0);
    chk("to_ready", {31'd0, req_ready}, 32'd1);
    chk("to_we", {31'd0, rf_wr_enable}, 32'd0);
    mem_resp_valid = 1'b1;
    tick();
    chk("to_err_clear", {31'd0, error}, 32'd0);
    tick();
    mem_resp_valid = 1'b0;
    chk("to_stray_busy", {31'd0, busy}, 32'd0);

    // Reset asserted during WAIT abandons the load.
    req_addr = 32'h0000_0500; req_funct3 = 3'b010; req_rd = 5'd3; mem_resp_data = 32'h1111_2222;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    chk("rw_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rw_busy", {31'd0, busy}, 32'd0);
    chk("rw_error", {31'd0, error}, 32'd0);
    chk("rw_we", {31'd0, rf_wr_enable}, 32'd0);
    chk("rw_data", rf_wr_data, 32'd0);
    chk("rw_memaddr", mem_addr, 32'd0);
    mem_resp_valid = 1'b1;
    tick();
    tick();
    mem_resp_valid = 1'b0;
    chk("rw_stray_busy", {31'd0, busy}, 32'd0);
    chk("rw_stray_err", {31'd0, error}, 32'd0);
    tick();

    chk("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_writeback_unit.md
LOAD_WRITEBACK_UNIT -- requirements
Module: load_writeback_unit

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16: number of WAIT cycles without a response before the load is aborted; legal range 1..255.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  load request present.
REQ-005 SHALL have port req_ready  output  1  unit can accept a request.
REQ-006 SHALL have port req_addr  input  32  byte address of the load.
REQ-007 SHALL have port req_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-008 SHALL have port req_rd  input  5  destination register index.
REQ-009 SHALL have port mem_rd_valid  output  1  data-memory read request.
REQ-010 SHALL have port mem_rd_ready  input  1  memory accepts the read.
REQ-011 SHALL have port mem_addr  output  32  word-aligned read address, equal to {addr[31:2],2'b00}.
REQ-012 SHALL have port mem_resp_valid  input  1  read data valid.
REQ-013 SHALL have port mem_resp_data  input  32  read data word.
REQ-014 SHALL have ports rf_wr_enable (output, 1), rf_wr_address (output, 5), rf_wr_data (output, 32) and rf_write_pattern (output, 3); together they drive the register-file write port.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port error  output  1  one-cycle pulse on an aborted or illegal load.

Function
REQ-017 SHALL implement the states IDLE, ISSUE, WAIT and WRITE.
REQ-018 SHALL drive req_ready=1 only in IDLE; a request is accepted on an edge where req_valid and req_ready are both high, and addr, funct3 and rd are captured at that edge.
REQ-019 SHALL, on an illegal accepted request, pulse error in the next cycle and remain in IDLE without a memory access; illegal means:
- funct3 011, 110 or 111;
- LW with addr[1:0]!=0;
- LH or LHU with addr[0]=1.
REQ-020 SHALL, on a legal accepted request, move IDLE->ISSUE.
REQ-021 SHALL, in ISSUE, hold mem_rd_valid=1 with a stable mem_addr until an edge where mem_rd_ready=1, then move to WAIT.
REQ-022 SHALL, in WAIT, capture mem_resp_data on an edge where mem_resp_valid=1 and move to WAIT->WRITE; mem_resp_valid SHALL be ignored in all other states.
REQ-023 SHALL count WAIT cycles; when the count reaches MEM_TIMEOUT with no response, it SHALL pulse error, perform no write, and return to IDLE; the counter SHALL clear on entry to WAIT.
REQ-024 SHALL, in WRITE, assert rf_wr_enable for exactly one cycle with rf_wr_address=rd and rf_write_pattern=REGISTER_WRITE_WORD, then move to IDLE.
REQ-025 SHALL suppress rf_wr_enable when rd=0, while still performing the memory access and all state transitions.
REQ-026 SHALL form rf_wr_data as follows:
- LB/LBU: select byte lane addr[1:0], then sign-extend (LB) or zero-extend (LBU);
- LH/LHU: select halfword addr[1], then sign-extend (LH) or zero-extend (LHU);
- LW: the full word.
REQ-027 SHALL hold rf_wr_data and rf_wr_address stable outside WRITE; rf_wr_enable SHALL be 0 outside WRITE.
REQ-028 SHALL have a minimum latency of 4 cycles from acceptance to the rf write (zero-wait memory), i.e. one cycle each in ISSUE, WAIT, WRITE, plus the acceptance edge.
REQ-029 SHALL NOT accept a new request until the edge after WRITE or after an error; back-to-back loads are therefore spaced by at least 4 cycles.

Reset
REQ-030 SHALL, when rst_n=0 at a clock edge, force:
- state=IDLE and the timeout counter to 0;
- req_ready=1 and busy=0;
- mem_rd_valid=0, rf_wr_enable=0 and error=0;
- rf_wr_address=0, rf_wr_data=0, rf_write_pattern=REGISTER_WRITE_WORD and mem_addr=0.
REQ-031 SHALL, on a reset asserted mid-operation (any state), abandon the load with no rf write and no error pulse, and ignore any later stray mem_resp_valid.

Configuration
REQ-032 SHALL, when macro LOAD_HALFWORD_EN is defined, support LH (001) and LHU (101) as in REQ-019/REQ-026.
REQ-033 SHALL, when LOAD_HALFWORD_EN is undefined, treat funct3 001 and 101 as illegal under REQ-019, and contain no halfword-extraction logic.

Verification
REQ-034 Bench SHALL cover LBU: addr=0x103, mem word 0x80AABBCC, rd=5, ready/resp immediate -> rf write 4 cycles after acceptance with rd=5, data=0x00000080.
REQ-035 Bench SHALL cover LB: addr=0x103, same word 0x80AABBCC -> data=0xFFFFFF80; LW at addr 0x100 -> data=0x80AABBCC.
REQ-036 Bench SHALL cover misaligned LW: addr=0x102 -> error=1 for one cycle, mem_rd_valid never asserted, no rf write, req_ready=1 on the following cycle.
REQ-037 Bench SHALL cover timeout: MEM_TIMEOUT=16 with no response -> error pulse on the 16th WAIT cycle, no rf write, state returns to IDLE.
REQ-038 Bench SHALL cover rd=0: LW accepted -> memory handshake occurs and rf_wr_enable stays 0; also rst_n=0 driven during WAIT -> no write, busy=0 on the next cycle.
REQ-039 Bench SHALL cover LH at addr 0x102 with word 0x80AABBCC: with LOAD_HALFWORD_EN -> data=0xFFFF80AA; without it -> error pulse and no memory access.
